// File: rtl/fetch_control_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encoding,
// datapath widths, the NOP word and the fetch range check.
package fetch_control_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    // True when a word address lies inside the instruction memory.
    // The compare is unsigned over all 64 bits, so a wrapped PC is caught.
    function automatic logic pc_in_range(input logic [XLEN-1:0] addr,
                                         input logic [XLEN-1:0] depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/fetch_control.sv
// Instruction-fetch sequencer. Owns the word-indexed PC, reads the
// instruction memory combinationally and registers the word into a single
// IF/ID slot with a valid/ready handshake toward the decoder. Handles
// branch redirects, halt requests and out-of-range fetch faults.
module fetch_control
    import fetch_control_pkg::*;
#(
    parameter int unsigned      MEM_DEPTH = 64,
    parameter logic [XLEN-1:0]  RESET_PC  = 64'd0
) (
    input  logic            clock,
    input  logic            reset,
    output logic [XLEN-1:0] pc,
    input  logic [ILEN-1:0] instrucao,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            halt_req,
    output logic            if_valid,
    output logic [ILEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            id_ready,
    output logic            fault,
    output logic [31:0]     fetch_count
);

    fetch_state_e    state_r;
    logic [XLEN-1:0] pc_r;
    logic            if_valid_r;
    logic [ILEN-1:0] if_instr_r;
    logic [XLEN-1:0] if_pc_r;
    logic            fault_r;
    logic [31:0]     fetch_count_r;

    logic            slot_free_s;
    logic            handshake_s;
    logic            in_range_s;

    // The slot can accept a new word when empty or being drained this cycle.
    assign slot_free_s = !if_valid_r || id_ready;
    assign handshake_s = if_valid_r && id_ready;
    assign in_range_s  = pc_in_range(pc_r, XLEN'(MEM_DEPTH));

    assign pc          = pc_r;
    assign if_valid    = if_valid_r;
    assign if_instr    = if_instr_r;
    assign if_pc       = if_pc_r;
    assign fault       = fault_r;
    assign fetch_count = fetch_count_r;

    // Fetch FSM: PC, IF/ID slot, fault flag and handshake counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_RUN;
            pc_r          <= RESET_PC;
            if_valid_r    <= 1'b0;
            if_instr_r    <= NOP;
            if_pc_r       <= 64'd0;
            fault_r       <= 1'b0;
            fetch_count_r <= 32'd0;
        end else begin
            // Handshakes count in every state, including redirect cycles.
            if (handshake_s) begin
                fetch_count_r <= fetch_count_r + 32'd1;
            end else begin
                fetch_count_r <= fetch_count_r;
            end

            case (state_r)
                ST_RUN, ST_HALT: begin
                    // halt_req alone selects RUN or HALT for the next cycle;
                    // leaving HALT and fetching happen in the same cycle.
                    state_r <= halt_req ? ST_HALT : ST_RUN;
                    if (redirect_valid) begin
                        // Redirect flushes the slot even under backpressure.
                        pc_r       <= redirect_target;
                        if_valid_r <= 1'b0;
                    end else if (!halt_req && slot_free_s) begin
                        if (in_range_s) begin
                            if_instr_r <= instrucao;
                            if_pc_r    <= pc_r;
                            if_valid_r <= 1'b1;
                            pc_r       <= pc_r + 64'd1;
                        end else begin
                            state_r    <= ST_FAULT;
                            fault_r    <= 1'b1;
                            if_valid_r <= 1'b0;
                        end
                    end else if (slot_free_s) begin
                        if_valid_r <= 1'b0;
                    end else begin
                        // Slot occupied and not consumed: slot and PC hold.
                        if_valid_r <= if_valid_r;
                    end
                end
                ST_FAULT: begin
                    // Absorbing until reset; PC keeps the faulting address.
                    state_r    <= ST_FAULT;
                    if_valid_r <= 1'b0;
                end
                default: begin
                    // Unreachable encoding: recover into a quiet RUN state.
                    state_r    <= ST_RUN;
                    if_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_control.sv
// Self-checking bench for fetch_control: a directed vector table covering
// stream, backpressure, redirect, halt, fault and reset, followed by
// randomized stimulus checked against a queue-based reference model.
module tb_fetch_control;

    logic        clock;
    logic        reset;
    logic [63:0] pc;
    logic [31:0] instrucao;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic        halt_req;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        id_ready;
    logic        fault;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [64];

    fetch_control #(.MEM_DEPTH(64), .RESET_PC(64'd0)) dut (
        .clock           (clock),
        .reset           (reset),
        .pc              (pc),
        .instrucao       (instrucao),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .id_ready        (id_ready),
        .fault           (fault),
        .fetch_count     (fetch_count)
    );

    // Instruction memory stand-in: combinational read.
    assign instrucao = (pc < 64'd64) ? mem[pc[5:0]] : 32'hDEAD_BEEF;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        rv;
        logic [63:0] rt;
        logic        hlt;
        logic        rdy;
        logic        ev;
        logic [63:0] eifpc;
        logic [63:0] epc;
        logic        efault;
        logic [31:0] ecnt;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic rv, input int rt,
                                input logic hlt, input logic rdy, input logic ev,
                                input int eifpc, input int epc, input logic efault,
                                input int ecnt);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rt = 64'(rt); v.hlt = hlt; v.rdy = rdy;
        v.ev = ev; v.eifpc = 64'(eifpc); v.epc = 64'(epc); v.efault = efault;
        v.ecnt = 32'(ecnt);
        return v;
    endfunction

    // Reference model state: a 0/1-entry slot queue, PC, fault flag, count.
    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } slot_t;

    slot_t       slot_q[$];
    logic [63:0] m_pc;
    logic        m_faulted;
    logic [31:0] m_count;

    task automatic model_step(input logic rst, input logic rv, input logic [63:0] rt,
                              input logic hlt, input logic rdy);
        bit had;
        bit free;
        slot_t s;
        if (rst) begin
            m_pc = 64'd0;
            slot_q.delete();
            m_faulted = 1'b0;
            m_count = 32'd0;
        end else begin
            had  = (slot_q.size() != 0);
            free = !had || rdy;
            if (had && rdy) begin
                m_count = m_count + 32'd1;
                void'(slot_q.pop_front());
            end
            if (!m_faulted) begin
                if (rv) begin
                    m_pc = rt;
                    slot_q.delete();
                end else if (free && !hlt) begin
                    if (m_pc < 64'd64) begin
                        s.pc = m_pc;
                        s.instr = mem[m_pc[5:0]];
                        slot_q.push_back(s);
                        m_pc = m_pc + 64'd1;
                    end else begin
                        m_faulted = 1'b1;
                        slot_q.delete();
                    end
                end
            end
        end
    endtask

    vec_t vecs[32];

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = {8'(i), 8'hA5, 16'(i * 7 + 3)};
        end
        mem[0]  = 32'h0000_0000;
        mem[1]  = 32'h0070_2083;
        mem[2]  = 32'h0153_8FB3;
        mem[10] = 32'hFFFF_1EE3;

        reset = 1'b1; redirect_valid = 1'b0; redirect_target = 64'd0;
        halt_req = 1'b0; id_ready = 1'b0;

        //          rst rv rt  hlt rdy | ev ifpc pc flt cnt
        vecs[0]  = mk(1, 0, 0,  0, 1,   0, 0,  0,  0, 0);
        vecs[1]  = mk(0, 0, 0,  0, 1,   1, 0,  1,  0, 0);
        vecs[2]  = mk(0, 0, 0,  0, 1,   1, 1,  2,  0, 1);
        vecs[3]  = mk(0, 0, 0,  0, 1,   1, 2,  3,  0, 2);
        vecs[4]  = mk(0, 0, 0,  0, 0,   1, 2,  3,  0, 2);
        vecs[5]  = mk(0, 0, 0,  0, 0,   1, 2,  3,  0, 2);
        vecs[6]  = mk(0, 0, 0,  0, 0,   1, 2,  3,  0, 2);
        vecs[7]  = mk(0, 0, 0,  0, 1,   1, 3,  4,  0, 3);
        vecs[8]  = mk(0, 0, 0,  0, 1,   1, 4,  5,  0, 4);
        vecs[9]  = mk(0, 0, 0,  0, 1,   1, 5,  6,  0, 5);
        vecs[10] = mk(0, 0, 0,  0, 1,   1, 6,  7,  0, 6);
        vecs[11] = mk(0, 0, 0,  0, 1,   1, 7,  8,  0, 7);
        vecs[12] = mk(0, 1, 10, 0, 1,   0, 0,  10, 0, 8);
        vecs[13] = mk(0, 0, 0,  0, 1,   1, 10, 11, 0, 8);
        vecs[14] = mk(0, 1, 20, 0, 0,   0, 0,  20, 0, 8);
        vecs[15] = mk(0, 0, 0,  0, 0,   1, 20, 21, 0, 8);
        vecs[16] = mk(0, 1, 4,  0, 1,   0, 0,  4,  0, 9);
        vecs[17] = mk(0, 0, 0,  0, 1,   1, 4,  5,  0, 9);
        vecs[18] = mk(0, 0, 0,  1, 0,   1, 4,  5,  0, 9);
        vecs[19] = mk(0, 0, 0,  1, 1,   0, 0,  5,  0, 10);
        vecs[20] = mk(0, 0, 0,  1, 1,   0, 0,  5,  0, 10);
        vecs[21] = mk(0, 1, 8,  1, 1,   0, 0,  8,  0, 10);
        vecs[22] = mk(0, 0, 0,  0, 1,   1, 8,  9,  0, 10);
        vecs[23] = mk(0, 1, 63, 0, 1,   0, 0,  63, 0, 11);
        vecs[24] = mk(0, 0, 0,  0, 1,   1, 63, 64, 0, 11);
        vecs[25] = mk(0, 0, 0,  0, 1,   0, 0,  64, 1, 12);
        vecs[26] = mk(0, 1, 0,  0, 1,   0, 0,  64, 1, 12);
        vecs[27] = mk(0, 0, 0,  0, 1,   0, 0,  64, 1, 12);
        vecs[28] = mk(1, 0, 0,  0, 1,   0, 0,  0,  0, 0);
        vecs[29] = mk(0, 0, 0,  0, 1,   1, 0,  1,  0, 0);
        vecs[30] = mk(1, 1, 9,  0, 1,   0, 0,  0,  0, 0);
        vecs[31] = mk(0, 0, 0,  0, 1,   1, 0,  1,  0, 0);

        // Directed vector table.
        for (int i = 0; i < 32; i++) begin
            reset           = vecs[i].rst;
            redirect_valid  = vecs[i].rv;
            redirect_target = vecs[i].rt;
            halt_req        = vecs[i].hlt;
            id_ready        = vecs[i].rdy;
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d_if_valid", i), 64'(if_valid), 64'(vecs[i].ev));
            chk($sformatf("vec%0d_pc", i), pc, vecs[i].epc);
            chk($sformatf("vec%0d_fault", i), 64'(fault), 64'(vecs[i].efault));
            chk($sformatf("vec%0d_fetch_count", i), 64'(fetch_count), 64'(vecs[i].ecnt));
            if (vecs[i].ev) begin
                chk($sformatf("vec%0d_if_pc", i), if_pc, vecs[i].eifpc);
                chk($sformatf("vec%0d_if_instr", i), 64'(if_instr), 64'(mem[vecs[i].eifpc[5:0]]));
            end
            if (i == 0) begin
                chk("reset_if_instr", 64'(if_instr), 64'd0);
                chk("reset_if_pc", if_pc, 64'd0);
            end
            if (i == 13) begin
                chk("redirect_target_word", 64'(if_instr), 64'h0000_0000_FFFF_1EE3);
            end
        end

        // Randomized stimulus against the reference model.
        reset = 1'b1; redirect_valid = 1'b0; halt_req = 1'b0; id_ready = 1'b1;
        model_step(1'b1, 1'b0, 64'd0, 1'b0, 1'b1);
        @(posedge clock);
        #1;
        for (int n = 0; n < 3000; n++) begin
            reset          = ($urandom_range(0, 199) == 0);
            redirect_valid = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_target = 64'($urandom_range(58, 63));
                1:       redirect_target = {$urandom, $urandom};
                default: redirect_target = 64'($urandom_range(0, 63));
            endcase
            halt_req = ($urandom_range(0, 5) == 0);
            id_ready = ($urandom_range(0, 3) != 0);
            model_step(reset, redirect_valid, redirect_target, halt_req, id_ready);
            @(posedge clock);
            #1;
            chk("rand_if_valid", 64'(if_valid), 64'(slot_q.size() != 0));
            chk("rand_pc", pc, m_pc);
            chk("rand_fault", 64'(fault), 64'(m_faulted));
            chk("rand_fetch_count", 64'(fetch_count), 64'(m_count));
            if (slot_q.size() != 0) begin
                chk("rand_if_pc", if_pc, slot_q[0].pc);
                chk("rand_if_instr", 64'(if_instr), 64'(slot_q[0].instr));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
